mac_tx_fcs_ctrl: RTL and testbench

TX-side frame sequencer that sits between the MAC TX byte stream and the PHY-facing byte stream. It steers each payload byte into the byte-wise CRC-32 engine and passes it downstream. After the last byte it appends the 4-byte Ethernet FCS, optionally preceded by zero padding. It owns all CRC engine control (enable, clear, data) so the engine is never driven directly by the MAC datapath.

---
 rtl/mac_tx_fcs_ctrl_if.sv | 28 ++
 rtl/mac_tx_fcs_ctrl.sv | 134 +++++++++++++
 tb/tb_mac_tx_fcs_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_tx_fcs_ctrl_if.sv
// Byte-stream, CRC-engine and status signals around mac_tx_fcs_ctrl.
// slave is the sequencer's view; master is the surrounding MAC/PHY/engine view.
interface mac_tx_fcs_ctrl_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic [7:0]  crc_data;
    logic        crc_en;
    logic        crc_clr;
    logic [31:0] crc_value;
    logic        busy;
    logic        frame_done;

    modport slave (
        input  s_data, s_valid, s_last, m_ready, crc_value,
        output s_ready, m_data, m_valid, m_last, crc_data, crc_en, crc_clr, busy, frame_done
    );

    modport master (
        output s_data, s_valid, s_last, m_ready, crc_value,
        input  s_ready, m_data, m_valid, m_last, crc_data, crc_en, crc_clr, busy, frame_done
    );
endinterface

// File: rtl/mac_tx_fcs_ctrl.sv
// TX frame sequencer: passes payload bytes through, drives the byte-wise CRC-32 engine, appends the FCS.
// Zero padding up to MIN_FRAME bytes is compiled in when MAC_TX_PAD_EN is defined.
module mac_tx_fcs_ctrl #(
    parameter int unsigned MIN_FRAME = 60,
    parameter int unsigned CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    mac_tx_fcs_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
`ifdef MAC_TX_PAD_EN
    localparam logic [1:0] ST_PAD  = 2'd2;
`endif
    localparam logic [1:0] ST_FCS  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      fcs;
    logic [7:0]       m_data, crc_data;
    logic             s_ready, m_valid, m_last, crc_en, crc_clr, busy, frame_done;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] b);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = b[31-i];
        return r;
    endfunction

    // Engine runs MSB-first on bit-reversed bytes, so the wire-order FCS is the reflected complement.
    assign fcs     = ~bitrev32(bus.crc_value);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

`ifndef MAC_TX_PAD_EN
    logic unused_min_frame;
    assign unused_min_frame = (MIN_FRAME == 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        s_ready    = 1'b0;
        m_data     = 8'h00;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        crc_data   = 8'h00;
        crc_en     = 1'b0;
        crc_clr    = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                crc_clr = 1'b1;
                busy    = 1'b0;
                if (bus.s_valid) state_d = ST_DATA;
            end
            ST_DATA: begin
                m_data   = bus.s_data;
                m_valid  = bus.s_valid;
                s_ready  = bus.m_ready;
                crc_en   = bus.s_valid & bus.m_ready;
                crc_data = bitrev8(bus.s_data);
                if (bus.s_valid && bus.m_ready) begin
                    cnt_d = cnt_inc;
                    if (bus.s_last) begin
`ifdef MAC_TX_PAD_EN
                        state_d = (cnt_inc < CNT_W'(MIN_FRAME)) ? ST_PAD : ST_FCS;
`else
                        state_d = ST_FCS;
`endif
                    end
                end
            end
`ifdef MAC_TX_PAD_EN
            ST_PAD: begin
                m_valid = 1'b1;
                crc_en  = bus.m_ready;
                if (bus.m_ready) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(MIN_FRAME)) state_d = ST_FCS;
                end
            end
`endif
            ST_FCS: begin
                m_valid = 1'b1;
                m_data  = fcs[{idx_q, 3'b000} +: 8];
                m_last  = (idx_q == 2'd3);
                if (bus.m_ready) begin
                    if (idx_q == 2'd3) begin
                        frame_done = 1'b1;
                        crc_clr    = 1'b1;
                        cnt_d      = '0;
                        idx_d      = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.s_ready    = s_ready;
    assign bus.m_data     = m_data;
    assign bus.m_valid    = m_valid;
    assign bus.m_last     = m_last;
    assign bus.crc_data   = crc_data;
    assign bus.crc_en     = crc_en;
    assign bus.crc_clr    = crc_clr;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_mac_tx_fcs_ctrl.sv
// Self-checking bench for mac_tx_fcs_ctrl: external CRC engine model plus a reflected software CRC reference.
module tb_mac_tx_fcs_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_tx_fcs_ctrl_if bus();
    mac_tx_fcs_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0;
    int errors = 0;
    logic [7:0] pay_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [31:0] eng_q;

    typedef struct {
        int len;
        int rmode;
        int exp_total;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [31:0] eng_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C11DB7;
        end
        return r;
    endfunction

    // Byte-wise CRC engine the sequencer drives; reset shared with crc_clr.
    always_ff @(posedge clk) begin
        if (rst || bus.crc_clr) eng_q <= 32'hFFFF_FFFF;
        else if (bus.crc_en)    eng_q <= eng_step(eng_q, bus.crc_data);
    end
    assign bus.crc_value = eng_q;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic int exp_total(input int n);
`ifdef MAC_TX_PAD_EN
        return ((n < 60) ? 60 : n) + 4;
`else
        return n + 4;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: wire bytes = payload (+ zero pad), then reflected CRC-32 low byte first.
    task automatic build_exp();
        logic [31:0] c;
        exp_q = {};
        foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
`ifdef MAC_TX_PAD_EN
        while (exp_q.size() < 60) exp_q.push_back(8'h00);
`endif
        c = 32'hFFFF_FFFF;
        foreach (exp_q[i]) begin
            c = c ^ {24'h0, exp_q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    endtask

    task automatic load_digits();
        pay_q = {};
        for (int i = 0; i < 9; i++) pay_q.push_back(8'(8'h31 + i));
    endtask

    // rmode: 0 m_ready high, 1 m_ready toggling, 2 random m_ready and s_valid gaps.
    task automatic send_frame(input int rmode, input bit hold_next, input logic [7:0] next_byte,
                              output int ntx);
        int nin, cyc;
        bit sv, pstall;
        logic [7:0] pm;
        build_exp();
        got_q = {};
        nin = 0; ntx = 0; cyc = 0; sv = 1'b0; pstall = 1'b0; pm = 8'h00;
        while (ntx < exp_q.size() && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (!sv) sv = (nin < pay_q.size()) && (rmode != 2 || $urandom_range(3) != 0);
            bus.s_valid = sv;
            bus.s_data  = sv ? pay_q[nin] : 8'h00;
            bus.s_last  = sv && (nin == pay_q.size() - 1);
            bus.m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 1) : ($urandom_range(3) != 0);
            #1;
            if (pstall && bus.m_valid) chk("m_data_hold", 32'(bus.m_data), 32'(pm));
            if (bus.m_valid) chk("busy_active", 32'(bus.busy), 32'd1);
            if (bus.crc_en) begin
                chk("crc_en_ready", 32'(bus.m_ready), 32'd1);
                chk("crc_data", 32'(bus.crc_data), 32'(rev8(bus.m_data)));
            end
            if (bus.m_valid && bus.m_ready) begin
                chk("m_data", 32'(bus.m_data), 32'(exp_q[ntx]));
                chk("m_last", 32'(bus.m_last), 32'(ntx == exp_q.size() - 1));
                chk("frame_done", 32'(bus.frame_done), 32'(ntx == exp_q.size() - 1));
                got_q.push_back(bus.m_data);
                ntx++;
            end
            if (bus.s_valid && bus.s_ready) begin
                nin++;
                sv = 1'b0;
            end
            pstall = bus.m_valid && !bus.m_ready;
            pm     = bus.m_data;
        end
        if (ntx < exp_q.size()) chk("frame_timeout", 32'(ntx), 32'(exp_q.size()));
        @(negedge clk);
        bus.s_valid = hold_next;
        bus.s_data  = next_byte;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        #1;
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_crc_clr", 32'(bus.crc_clr), 32'd1);
        chk("idle_m_valid", 32'(bus.m_valid), 32'd0);
    endtask

    task automatic chk_digits_fcs();
`ifndef MAC_TX_PAD_EN
        chk("fcs0", 32'(got_q[9]), 32'h26);
        chk("fcs1", 32'(got_q[10]), 32'h39);
        chk("fcs2", 32'(got_q[11]), 32'hF4);
        chk("fcs3", 32'(got_q[12]), 32'hCB);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int ntx;
        int len;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        vecs[0] = '{len: 14, rmode: 0, exp_total: exp_total(14)};
        vecs[1] = '{len: 60, rmode: 0, exp_total: 64};
        vecs[2] = '{len: 59, rmode: 1, exp_total: exp_total(59)};
        vecs[3] = '{len: 61, rmode: 2, exp_total: 65};
        vecs[4] = '{len: 1,  rmode: 1, exp_total: exp_total(1)};
        vecs[5] = '{len: 14, rmode: 1, exp_total: exp_total(14)};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_crc_clr", 32'(bus.crc_clr), 32'd1);
        chk("rst_crc_en", 32'(bus.crc_en), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);

        // Reference frame "123456789".
        load_digits();
        send_frame(0, 1'b0, 8'h00, ntx);
        chk("digits_count", 32'(ntx), 32'(exp_total(9)));
        chk_digits_fcs();

        for (int i = 0; i < 6; i++) begin
            pay_q = {};
            for (int j = 0; j < vecs[i].len; j++) pay_q.push_back(8'($urandom));
            send_frame(vecs[i].rmode, 1'b0, 8'h00, ntx);
            chk("vec_tx_count", 32'(ntx), 32'(vecs[i].exp_total));
        end

        // Back-to-back frames with s_valid held through the single IDLE cycle.
        pay_q = {};
        for (int j = 0; j < 20; j++) pay_q.push_back(8'($urandom));
        send_frame(0, 1'b1, 8'h31, ntx);
        load_digits();
        send_frame(0, 1'b0, 8'h00, ntx);
        chk_digits_fcs();

        // Reset presented with payload byte 5.
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.s_data = 8'(8'hA0 + i);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        chk("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_crc_clr", 32'(bus.crc_clr), 32'd1);
        load_digits();
        send_frame(0, 1'b0, 8'h00, ntx);
        chk_digits_fcs();

        // Randomized frames, lengths and handshakes.
        for (int f = 0; f < 16; f++) begin
            len = $urandom_range(90, 1);
            pay_q = {};
            for (int j = 0; j < len; j++) pay_q.push_back(8'($urandom));
            send_frame(2, 1'b0, 8'h00, ntx);
            chk("rand_tx_count", 32'(ntx), 32'(exp_total(len)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
